// File: rtl/mx_pkg.sv
// Shared types and arithmetic for the MX block quantizer: FSM states,
// floating-point field extraction and the per-element MXINT quantize step.
package mx_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    EMIT    = 2'd2
  } state_t;

  function automatic logic fp_sign(input logic [63:0] d, input int exp_w, input int man_w);
    logic [63:0] t;
    t = d >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [31:0] fp_exp(input logic [63:0] d, input int exp_w, input int man_w);
    logic [63:0] t;
    t = (d >> man_w) & ((64'd1 << exp_w) - 64'd1);
    return t[31:0];
  endfunction

  function automatic logic [31:0] fp_man(input logic [63:0] d, input int man_w);
    logic [63:0] t;
    t = d & ((64'd1 << man_w) - 64'd1);
    return t[31:0];
  endfunction

  // Scale is the block max exponent, so scale - e never underflows; the
  // result is truncated toward zero and always fits without saturation.
  function automatic logic [31:0] quantize(input logic s, input logic [31:0] e,
                                           input logic [31:0] m, input logic [31:0] scale,
                                           input int man_w, input int out_w);
    logic [31:0] sig, sh, mag;
    sig = (e != 32'd0) ? ((32'd1 << man_w) | m) : 32'd0;
    sh  = scale - e;
    mag = (sh >= 32'(man_w + 1)) ? 32'd0 : ((sig >> sh) >> (man_w - (out_w - 2)));
    return s ? (32'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/unsigned_max.sv
// Combinational maximum over `length` packed unsigned fields of `width` bits.
module unsigned_max #(
  parameter int width  = 8,
  parameter int length = 32
) (
  input  logic [width*length-1:0] i_data,
  output logic [width-1:0]        o_max
);

  always_comb begin
    o_max = '0;
    for (int i = 0; i < length; i++) begin
      if (i_data[i*width +: width] > o_max) o_max = i_data[i*width +: width];
    end
  end

endmodule

// File: rtl/mx_block_quantizer.sv
// Streaming MX quantizer: buffers one block of FP elements, registers the max
// exponent as shared scale, then emits one MXINT element per accepted beat.
module mx_block_quantizer
  import mx_pkg::*;
#(
  parameter int exp_width = 8,
  parameter int man_width = 7,
  parameter int length    = 32,
  parameter int out_width = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [exp_width+man_width:0] i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [out_width-1:0]         o_data,
  output logic [exp_width-1:0]         o_scale,
  output logic                         o_last
);

  localparam int dw = 1 + exp_width + man_width;
  localparam int cw = $clog2(length);
  localparam logic [cw-1:0] last_idx = cw'(length - 1);

  state_t                      state, state_nxt;
  logic [cw-1:0]               wr_cnt, rd_idx;
  logic [dw-1:0]               mem [length];
  logic [exp_width*length-1:0] exps;
  logic [exp_width-1:0]        e_max;
  logic [dw-1:0]               cur;
  logic                        wr_en, rd_en;

  // Reset gates the write strobe so nothing lands in the buffer while held in reset.
  assign wr_en = i_valid && o_ready && i_rst_n;
  assign rd_en = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (wr_en && wr_cnt == last_idx) state_nxt = SCALE;
      SCALE:   state_nxt = EMIT;
      EMIT:    if (rd_en && rd_idx == last_idx) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    o_ready = (state == COLLECT);
    o_valid = (state == EMIT);
    o_last  = (state == EMIT) && (rd_idx == last_idx);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt  <= '0;
      rd_idx  <= '0;
      o_scale <= '0;
    end else begin
      if (wr_en) wr_cnt <= (wr_cnt == last_idx) ? '0 : wr_cnt + 1'b1;
      if (rd_en) rd_idx <= (rd_idx == last_idx) ? '0 : rd_idx + 1'b1;
      if (state == SCALE) o_scale <= e_max;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_cnt] <= i_data;
  end

  always_comb begin
    exps = '0;
    for (int i = 0; i < length; i++) begin
      exps[i*exp_width +: exp_width] = exp_width'(fp_exp(64'(mem[i]), exp_width, man_width));
    end
  end

  unsigned_max #(
    .width (exp_width),
    .length(length)
  ) u_max (
    .i_data(exps),
    .o_max (e_max)
  );

  assign cur    = mem[rd_idx];
  assign o_data = out_width'(quantize(fp_sign(64'(cur), exp_width, man_width),
                                      fp_exp(64'(cur), exp_width, man_width),
                                      fp_man(64'(cur), man_width),
                                      32'(o_scale), man_width, out_width));

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed bench for mx_block_quantizer with bf16 elements, 8-bit MXINT, 32-element blocks.
module tb_mx_block_quantizer;

  localparam int L = 32;
  typedef logic [15:0] blk_t [L];
  typedef logic [7:0]  ob_t  [L];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_ready, o_valid, o_last;
  logic [7:0]  o_data, o_scale;

  int checks = 0;
  int passed = 0;

  ob_t        got_d;
  logic       got_l [L];
  logic [7:0] got_s;
  logic [7:0] held_d [3];
  logic       held_l [3];
  int         lat;
  bit         feed_ok, drain_ok;

  always #5 clk = ~clk;

  mx_block_quantizer #(
    .exp_width(8), .man_width(7), .length(L), .out_width(8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_scale(o_scale),
    .o_last (o_last)
  );

  task automatic feed(input blk_t d, input bit gaps);
    int  n = 0;
    int  guard = 0;
    bit  fire;
    while (n < L && guard < 500) begin
      i_valid = !(gaps && (guard % 3 == 1));
      i_data  = d[n];
      @(negedge clk);
      fire = i_valid && o_ready;
      @(posedge clk); #1;
      if (fire) n++;
      guard++;
    end
    i_valid = 1'b0;
    feed_ok = (n == L);
  endtask

  task automatic drain(input int stall_at);
    int n = 0;
    int guard = 0;
    int stall = 0;
    lat = -1;
    while (n < L && guard < 500) begin
      i_ready = !(n == stall_at && stall < 3);
      @(negedge clk);
      if (o_valid && lat < 0) lat = guard;
      if (o_valid && i_ready) begin
        got_d[n] = o_data; got_l[n] = o_last; got_s = o_scale; n++;
      end else if (o_valid && stall < 3) begin
        held_d[stall] = o_data; held_l[stall] = o_last; stall++;
      end
      @(posedge clk); #1;
      guard++;
    end
    i_ready  = 1'b0;
    drain_ok = (n == L);
  endtask

  task automatic test_reset;
    i_valid = 1'b1; i_data = 16'h4000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else passed++;
    checks++; if (o_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", o_last); else passed++;
    checks++; if (o_scale !== 8'd0) $display("FAIL reset_scale got=%0d exp=0", o_scale); else passed++;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", o_ready); else passed++;
    i_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones;
    blk_t d;
    for (int i = 0; i < L; i++) d[i] = 16'h3F80;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL ones_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (lat !== 1) $display("FAIL ones_latency got=%0d exp=1", lat); else passed++;
    checks++; if (got_s !== 8'd127) $display("FAIL ones_scale got=%0d exp=127", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== 8'd64 || got_l[i] !== (i == L-1))
        $display("FAIL ones_elem%0d got=%h/%b exp=40/%b", i, got_d[i], got_l[i], i == L-1);
      else passed++;
    end
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) $display("FAIL ones_back_to_collect valid=%b ready=%b exp=0/1", o_valid, o_ready); else passed++;
  endtask

  task automatic test_scale_max;
    blk_t d;
    for (int i = 0; i < L; i++) d[i] = (i == 0) ? 16'h4000 : 16'h3F80;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL max_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd128) $display("FAIL max_scale got=%0d exp=128", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== ((i == 0) ? 8'd64 : 8'd32))
        $display("FAIL max_elem%0d got=%0d exp=%0d", i, got_d[i], (i == 0) ? 64 : 32);
      else passed++;
    end
  endtask

  task automatic test_negative;
    blk_t d;
    for (int i = 0; i < L; i++) d[i] = (i == 7) ? 16'hBFC0 : 16'h3F80;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL neg_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd127) $display("FAIL neg_scale got=%0d exp=127", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== ((i == 7) ? 8'hA0 : 8'h40))
        $display("FAIL neg_elem%0d got=%h exp=%h", i, got_d[i], (i == 7) ? 8'hA0 : 8'h40);
      else passed++;
    end
  endtask

  task automatic test_zero_and_tiny;
    blk_t d;
    for (int i = 0; i < L; i++) d[i] = 16'h0000;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL zero_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd0) $display("FAIL zero_scale got=%0d exp=0", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++; if (got_d[i] !== 8'd0) $display("FAIL zero_elem%0d got=%0d exp=0", i, got_d[i]); else passed++;
    end
    for (int i = 0; i < L; i++) d[i] = (i == 3) ? 16'h3A80 : 16'h3F80;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL tiny_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd127) $display("FAIL tiny_scale got=%0d exp=127", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== ((i == 3) ? 8'd0 : 8'd64))
        $display("FAIL tiny_elem%0d got=%0d exp=%0d", i, got_d[i], (i == 3) ? 0 : 64);
      else passed++;
    end
  endtask

  // Element i = +/-(1 + 4i/128): quantizes to +/-(64+2i), negative when i%5==0.
  task automatic test_back_to_back;
    blk_t d;
    ob_t  e;
    for (int i = 0; i < L; i++) begin
      d[i] = {(i % 5 == 0) ? 1'b1 : 1'b0, 8'd127, 7'(i * 4)};
      e[i] = (i % 5 == 0) ? 8'(-(64 + 2*i)) : 8'(64 + 2*i);
    end
    feed(d, 1'b0);
    drain(4);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL stall_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (held_d[k] !== e[4] || held_l[k] !== 1'b0)
        $display("FAIL stall_hold%0d got=%h/%b exp=%h/0", k, held_d[k], held_l[k], e[4]);
      else passed++;
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== e[i] || got_l[i] !== (i == L-1))
        $display("FAIL stall_elem%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], e[i], i == L-1);
      else passed++;
    end
    feed(d, 1'b1);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL gap_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd127) $display("FAIL gap_scale got=%0d exp=127", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== e[i] || got_l[i] !== (i == L-1))
        $display("FAIL gap_elem%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], e[i], i == L-1);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_block;
    blk_t d;
    int   n = 0;
    int   guard = 0;
    for (int i = 0; i < L; i++) d[i] = 16'h3F80;
    feed(d, 1'b0);
    i_ready = 1'b1;
    while (n < 5 && guard < 100) begin
      @(negedge clk);
      if (o_valid) n++;
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (o_valid !== 1'b1 || n != 5) $display("FAIL abort_pre_valid got=%b beats=%0d exp=1/5", o_valid, n); else passed++;
    i_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", o_valid); else passed++;
    checks++; if (o_last !== 1'b0) $display("FAIL abort_last got=%b exp=0", o_last); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Partial 2.0 block aborted by reset must not leak into the next block's scale.
    i_valid = 1'b1; i_data = 16'h4000;
    repeat (10) @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    feed(d, 1'b0);
    drain(-1);
    checks++; if (!(feed_ok && drain_ok)) $display("FAIL abort_timeout feed=%b drain=%b exp=1/1", feed_ok, drain_ok); else passed++;
    checks++; if (got_s !== 8'd127) $display("FAIL abort_scale got=%0d exp=127", got_s); else passed++;
    for (int i = 0; i < L; i++) begin
      checks++;
      if (got_d[i] !== 8'd64 || got_l[i] !== (i == L-1))
        $display("FAIL abort_elem%0d got=%h/%b exp=40/%b", i, got_d[i], got_l[i], i == L-1);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_ones;
    test_scale_max;
    test_negative;
    test_zero_and_tiny;
    test_back_to_back;
    test_reset_mid_block;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
